// File: rtl/nibble_add_sequencer_if.sv
// Request/response handshake bundle for the nibble add sequencer.
// master = client side, slave = sequencer side.
interface nibble_add_sequencer_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_sub;
  logic         req_cin;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_ovf;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_sub,
    output req_cin,
    input  req_ready,
    input  rsp_valid,
    input  rsp_sum,
    input  rsp_cout,
    input  rsp_ovf,
    output rsp_ready
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_sub,
    input  req_cin,
    output req_ready,
    output rsp_valid,
    output rsp_sum,
    output rsp_cout,
    output rsp_ovf,
    input  rsp_ready
  );
endinterface

// File: rtl/nibble_add_sequencer.sv
// Wide add/subtract built from one external 4-bit adder,
// one nibble per cycle, LSB first.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  nibble_add_sequencer_if.slave bus,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_cin,
  input  logic [3:0] add_sum,
  input  logic       add_cout,
  output logic       busy
);
  localparam int KW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                  state;
  logic [NIBBLES-1:0][3:0] a_q;
  logic [NIBBLES-1:0][3:0] b_q;
  logic [NIBBLES-1:0][3:0] sum_q;
  logic                    c_q;
  logic                    cout_q;
  logic                    ovf_q;
  logic [KW-1:0]           k_q;
  logic                    last;
  logic                    run;

  assign run  = (state == RUN);
  assign last = (k_q == KW'(NIBBLES - 1));

  // carry-in comes from c_q only, so there is no loop through the adder
  assign add_a   = run ? a_q[k_q] : 4'h0;
  assign add_b   = run ? b_q[k_q] : 4'h0;
  assign add_cin = run & c_q;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == DONE);
  assign busy          = (state != IDLE);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_ovf   = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      k_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_q    <= bus.req_a;
            b_q    <= bus.req_sub ? ~bus.req_b : bus.req_b;
            c_q    <= bus.req_sub | bus.req_cin;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            k_q    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_q[k_q] <= add_sum;
          c_q        <= add_cout;
          k_q        <= k_q + 1'b1;
          if (last) begin
            cout_q <= add_cout;
            // carry into MSB xor carry out of MSB
            ovf_q  <= add_cout ^ (a_q[NIBBLES-1][3] ^
                                  b_q[NIBBLES-1][3] ^
                                  add_sum[3]);
            k_q    <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Scoreboard bench for nibble_add_sequencer with a
// behavioural 4-bit adder closing the datapath loop.
module tb_nibble_add_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_sum;
  logic       add_cout;
  logic       busy;

  int   checks;
  int   errors;
  int   acc_cnt;
  logic [3:0] first_b;
  logic [3:0] cin_seq;
  exp_t sb[$];

  nibble_add_sequencer_if #(.NIBBLES(N)) bus ();

  nibble_add_sequencer #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy)
  );

  always_comb begin
    {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    exp_t e;
    logic [W-1:0] bp;
    logic [W:0]   r;
    bp = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (sub | cin)};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (a[W-1] == bp[W-1]) && (r[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub, input logic cin);
    int n;
    @(negedge clk);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sub   = sub;
    bus.req_cin   = cin;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n == 64) begin
      chk("req_timeout", 64'd1, 64'd0);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(model(a, b, sub, cin));
    acc_cnt++;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_a     = W'($urandom);
    bus.req_b     = W'($urandom);
    bus.req_sub   = 1'($urandom);
    bus.req_cin   = 1'($urandom);
    first_b       = add_b;
  endtask

  task automatic collect(input int hold);
    int   lat;
    int   base;
    exp_t e;
    lat = 0;
    cin_seq = '0;
    while (!bus.rsp_valid && lat < 64) begin
      if (busy && lat < 4) cin_seq[lat] = add_cin;
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(N));
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    base = acc_cnt;
    chk("rsp_sum", 64'(bus.rsp_sum), 64'(e.sum));
    chk("rsp_cout", 64'(bus.rsp_cout), 64'(e.cout));
    chk("rsp_ovf", 64'(bus.rsp_ovf), 64'(e.ovf));
    chk("done_ready", 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_sum", 64'(bus.rsp_sum), 64'(e.sum));
      chk("hold_cout", 64'(bus.rsp_cout), 64'(e.cout));
      chk("hold_ovf", 64'(bus.rsp_ovf), 64'(e.ovf));
      chk("hold_ready", 64'(bus.req_ready), 64'd0);
      chk("hold_noacc", 64'(acc_cnt), 64'(base));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_valid", 64'(bus.rsp_valid), 64'd0);
    chk("post_ready", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_sum"}, 64'(bus.rsp_sum), 64'd0);
    chk({tag, "_rsp_cout"}, 64'(bus.rsp_cout), 64'd0);
    chk({tag, "_rsp_ovf"}, 64'(bus.rsp_ovf), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_add"}, 64'({add_a, add_b, add_cin}), 64'd0);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic sub, input logic cin);
    send(a, b, sub, cin);
    collect(0);
  endtask

  initial begin
    int base;
    checks        = 0;
    errors        = 0;
    acc_cnt       = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = 1'b0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    send(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    collect(0);
    chk("cin_seq", 64'(cin_seq), 64'h0E);

    op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0000, 1'b0, 1'b1);
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    op(16'h8000, 16'h0001, 1'b1, 1'b0);

    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    chk("sub_b0", 64'(first_b), 64'h8);
    collect(0);

    base = acc_cnt;
    fork
      begin
        send(16'hABCD, 16'h1111, 1'b0, 1'b1);
        collect(3);
      end
      begin
        wait (acc_cnt == base + 1);
        @(negedge clk);
        @(negedge clk);
        send(16'h4000, 16'h5000, 1'b1, 1'b0);
        collect(0);
      end
    join

    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("mid");
    void'(sb.pop_front());
    repeat (2) begin
      @(negedge clk);
      chk("mid_noval", 64'(bus.rsp_valid), 64'd0);
    end
    rst_n = 1'b1;
    op(16'h00FF, 16'h0001, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
